pwm_peripheral: RTL and testbench
=================================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 en_out  input  8  per-output enable, bit i = out[i].
REQ-004 en_pwm_out  input  8  per-output mode: 1 = PWM, 0 = static high.
REQ-005 out_3_0_sel  input  8  2-bit source select per output 0..3, out[i] at bits [2i+1:2i].
REQ-006 out_7_4_sel  input  8  2-bit source select per output 4..7, out[i] at bits [2(i-4)+1:2(i-4)].
REQ-007 gen0_ch0_duty, gen0_ch1_duty, gen1_ch0_duty, gen1_ch1_duty  input  8 each  channel duty, 0..255.
REQ-008 freq_div  input  8  [3:0] = generator 0 divider, [7:4] = generator 1 divider.
REQ-009 out  output  8  registered output pins.
REQ-010 gen_wrap  output  2  1-cycle pulse per generator on period wrap; status only.

Function
REQ-011 Two independent generators, each with a 4-bit prescaler (pre), an 8-bit period counter (cnt) and shadow registers div_sh (4b), duty_sh0/duty_sh1 (8b).
REQ-012 Tick: when pre == div_sh, assert tick and set pre to 0; otherwise pre increments by 1.
REQ-013 On tick, cnt increments by 1 modulo 256; cnt holds between ticks.
REQ-014 On tick with cnt == 255: cnt becomes 0; div_sh, duty_sh0 and duty_sh1 load from the inputs in the same cycle; gen_wrap[g] pulses for that cycle.
REQ-015 Input changes mid-period have no effect until the next wrap, so there are no partial or glitched periods.
REQ-016 PWM period = 256 x (div_sh + 1) clk cycles; div_sh 0 => 256 cycles, div_sh 15 => 4096 cycles.
REQ-017 Channel level = 1 when duty_sh == 255, otherwise cnt < duty_sh.
REQ-018 Duty 0 gives a constant low level; duty 255 gives a constant high level (100 %, not 255/256).
REQ-019 Source encoding: 0 = gen0 ch0, 1 = gen0 ch1, 2 = gen1 ch0, 3 = gen1 ch1.
REQ-020 Next value of out[i]:
- 0 if en_out[i] == 0;
- 1 if en_out[i] == 1 and en_pwm_out[i] == 0;
- the selected source level otherwise.
REQ-021 Latency: out[i] reflects a change of en_out, en_pwm_out or select exactly one clk later; duty and divider changes follow REQ-014.
REQ-022 Several outputs may select the same source; each output evaluates independently.
REQ-023 Generators run continuously regardless of enables; disabling an output does not reset its generator.

Reset
REQ-024 While rst = 1: pre, cnt, div_sh, duty_sh0, duty_sh1, out and gen_wrap are all 0.
REQ-025 Reset asserted mid-period aborts the period immediately (asynchronously); after release, counting restarts from pre = 0 and cnt = 0.
REQ-026 After reset, the first period runs with zero shadows (PWM outputs low); input values take effect from the first wrap, 256 x 1 cycles after release at divider 0.

Structure
REQ-027 Shared package pwm_pkg holds the source-select encoding constants, CNT_MAX = 255 and the divider/counter widths.
REQ-028 A sub-module pwm_gen contains one generator (prescaler, counter, shadows, two channel compares, wrap pulse) and is instantiated twice; pwm_peripheral holds the output mux and output register.

Verification
REQ-029 en_out = 0x01, en_pwm_out = 0x00 -> out = 0x01 one cycle later; en_out = 0x00 -> out = 0x00 one cycle later.
REQ-030 freq_div = 0x00, gen0_ch0_duty = 128, out[0] in PWM with select 0, after the first wrap -> out[0] high 128 cycles and low 128 cycles, repeating every 256 cycles.
REQ-031 Duty 0 and duty 255 on gen1 ch0/ch1, routed to out[6] and out[7] -> out[6] constantly 0 and out[7] constantly 1 across at least 3 periods.
REQ-032 freq_div = 0x30 (gen1 divider 3), gen1_ch1_duty = 64 -> gen1 period 1024 cycles, high for 256 cycles; gen0 period stays 256 cycles.
REQ-033 Duty changed from 64 to 192 mid-period -> current period still 64 high; the next period after the gen_wrap pulse is 192 high.
REQ-034 rst pulsed mid-period with out = 0xFF in PWM mode -> out = 0x00 immediately; after release the first gen_wrap occurs 256 cycles later at divider 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helpers for the PWM peripheral: counter/divider widths,
// the counter terminal value, the 2-bit source-select encoding and small
// functions for the channel compare and the per-output select field.
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int DIV_W   = 4;   // prescaler / divider width
   localparam int CNT_W   = 8;   // period counter / duty width
   localparam int NUM_OUT = 8;   // number of output pins
   localparam int NUM_GEN = 2;   // number of generators

   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

   typedef logic [1:0] src_sel_t;

   // Source-select encoding shared by every output.
   localparam src_sel_t SRC_G0_CH0 = 2'd0;
   localparam src_sel_t SRC_G0_CH1 = 2'd1;
   localparam src_sel_t SRC_G1_CH0 = 2'd2;
   localparam src_sel_t SRC_G1_CH1 = 2'd3;

   // Duty CNT_MAX is a true 100 % level, not 255/256.
   function automatic logic ch_level(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] duty);
      return (duty == CNT_MAX) || (cnt < duty);
   endfunction

   // Outputs 0..3 take their select from s30, outputs 4..7 from s74.
   function automatic src_sel_t out_sel(input int idx,
                                        input logic [7:0] s30,
                                        input logic [7:0] s74);
      if (idx < 4) return s30[2*idx +: 2];
      else         return s74[2*(idx-4) +: 2];
   endfunction

endpackage

// File: rtl/pwm_if.sv
// -----------------------------------------------------------------------------
// pwm_if
// Register-side bundle of the PWM peripheral.
//   en_out       : per-output enable
//   en_pwm_out   : per-output mode (1 = PWM, 0 = static high)
//   out_3_0_sel  : 2-bit source selects for outputs 0..3
//   out_7_4_sel  : 2-bit source selects for outputs 4..7
//   genX_chY_duty: channel duties
//   freq_div     : [3:0] generator 0 divider, [7:4] generator 1 divider
//   out          : registered output pins
//   gen_wrap     : per-generator period-wrap status pulse
// master drives the configuration, slave is the peripheral.
// -----------------------------------------------------------------------------
interface pwm_if;
   import pwm_pkg::*;

   logic [NUM_OUT-1:0] en_out;
   logic [NUM_OUT-1:0] en_pwm_out;
   logic [7:0]         out_3_0_sel;
   logic [7:0]         out_7_4_sel;
   logic [CNT_W-1:0]   gen0_ch0_duty;
   logic [CNT_W-1:0]   gen0_ch1_duty;
   logic [CNT_W-1:0]   gen1_ch0_duty;
   logic [CNT_W-1:0]   gen1_ch1_duty;
   logic [7:0]         freq_div;
   logic [NUM_OUT-1:0] out;
   logic [NUM_GEN-1:0] gen_wrap;

   modport master (
      output en_out, en_pwm_out, out_3_0_sel, out_7_4_sel,
             gen0_ch0_duty, gen0_ch1_duty, gen1_ch0_duty, gen1_ch1_duty,
             freq_div,
      input  out, gen_wrap
   );

   modport slave (
      input  en_out, en_pwm_out, out_3_0_sel, out_7_4_sel,
             gen0_ch0_duty, gen0_ch1_duty, gen1_ch0_duty, gen1_ch1_duty,
             freq_div,
      output out, gen_wrap
   );

endinterface

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// One PWM generator: 4-bit prescaler, 8-bit period counter, shadowed divider
// and two shadowed duties, two channel compares and a wrap pulse.
//   clk, rst : clock, asynchronous active-high reset
//   i_div    : divider input (loaded into the shadow on wrap)
//   i_duty0/1: channel duties (loaded into the shadows on wrap)
//   o_lvl0/1 : channel levels (combinational from registered state)
//   o_wrap   : high for the one cycle that starts a new period
// -----------------------------------------------------------------------------
module pwm_gen
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] i_div,
   input  logic [CNT_W-1:0] i_duty0,
   input  logic [CNT_W-1:0] i_duty1,
   output logic             o_lvl0,
   output logic             o_lvl1,
   output logic             o_wrap
);

   logic [DIV_W-1:0] r_pre;
   logic [DIV_W-1:0] r_div_sh;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_duty_sh0;
   logic [CNT_W-1:0] r_duty_sh1;
   logic             r_wrap;

   logic w_tick;
   logic w_last;

   assign w_tick = (r_pre == r_div_sh);
   // Last tick of the period: the counter rolls over and the shadows reload.
   assign w_last = w_tick && (r_cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre      <= '0;
         r_cnt      <= '0;
         r_div_sh   <= '0;
         r_duty_sh0 <= '0;
         r_duty_sh1 <= '0;
         r_wrap     <= 1'b0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + DIV_W'(1);

         // Natural 8-bit overflow gives the modulo-256 count.
         if (w_tick) r_cnt <= r_cnt + CNT_W'(1);

         // Shadows change only at the period boundary, so a period is never
         // split between old and new settings.
         if (w_last) begin
            r_div_sh   <= i_div;
            r_duty_sh0 <= i_duty0;
            r_duty_sh1 <= i_duty1;
         end

         // Pulse coincides with the first cycle running on the new shadows.
         r_wrap <= w_last;
      end
   end

   assign o_lvl0 = ch_level(r_cnt, r_duty_sh0);
   assign o_lvl1 = ch_level(r_cnt, r_duty_sh1);
   assign o_wrap = r_wrap;

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Two PWM generators routed to eight registered output pins. Each pin is
// either off, static high, or follows one of the four generator channels.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : pwm_if.slave configuration inputs and out/gen_wrap outputs
// Generators run regardless of the pin enables.
// -----------------------------------------------------------------------------
module pwm_peripheral
   import pwm_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   pwm_if.slave  bus
);

   logic [3:0]         w_src;       // channel levels, indexed by source code
   logic [NUM_GEN-1:0] w_wrap;
   logic [NUM_OUT-1:0] w_out_nxt;
   logic [NUM_OUT-1:0] r_out;

   pwm_gen u_gen0 (
      .clk     (clk),
      .rst     (rst),
      .i_div   (bus.freq_div[3:0]),
      .i_duty0 (bus.gen0_ch0_duty),
      .i_duty1 (bus.gen0_ch1_duty),
      .o_lvl0  (w_src[SRC_G0_CH0]),
      .o_lvl1  (w_src[SRC_G0_CH1]),
      .o_wrap  (w_wrap[0])
   );

   pwm_gen u_gen1 (
      .clk     (clk),
      .rst     (rst),
      .i_div   (bus.freq_div[7:4]),
      .i_duty0 (bus.gen1_ch0_duty),
      .i_duty1 (bus.gen1_ch1_duty),
      .o_lvl0  (w_src[SRC_G1_CH0]),
      .o_lvl1  (w_src[SRC_G1_CH1]),
      .o_wrap  (w_wrap[1])
   );

   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned
      // and no latch is inferred.
      w_out_nxt = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (!bus.en_out[i])
            w_out_nxt[i] = 1'b0;
         else if (!bus.en_pwm_out[i])
            w_out_nxt[i] = 1'b1;
         else
            w_out_nxt[i] = w_src[out_sel(i, bus.out_3_0_sel, bus.out_7_4_sel)];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_out <= '0;
      else     r_out <= w_out_nxt;
   end

   assign bus.out      = r_out;
   assign bus.gen_wrap = w_wrap;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Self-checking bench for pwm_peripheral: a table of routing/enable vectors
// plus hand-written sequences for reset, periods, dividers and shadowing.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

   logic clk = 1'b0;
   logic rst;

   pwm_if bus ();

   pwm_peripheral dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      name;
      logic [7:0] en;
      logic [7:0] pwm;
      logic [7:0] s30;
      logic [7:0] s74;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until gen_wrap[g] is seen, -1 on timeout.
   task automatic wait_wrap(input int g, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (bus.gen_wrap[g]) begin
            n = i;
            break;
         end
      end
   endtask

   // Samples out[0] over one 256-cycle gen0 period starting right after a
   // wrap sample; optionally rewrites gen0_ch0_duty at sample change_at.
   task automatic sample_g0(input int change_at, input logic [7:0] new_duty,
                            output int ones, output int first_low);
      ones      = 0;
      first_low = -1;
      for (int i = 0; i < 256; i++) begin
         step();
         if (bus.out[0]) ones++;
         else if (first_low < 0) first_low = i;
         if (i == change_at) bus.gen0_ch0_duty = new_duty;
      end
   endtask

   initial begin
      int n, ones, first_low, bad, g0_wraps;

      // Expected values assume source levels 0,1,1,0 (duties 0,255,255,0).
      vecs[0] = '{"static_out0",   8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
      vecs[1] = '{"all_disabled",  8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{"static_all",    8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
      vecs[3] = '{"pwm_src0_all",  8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{"pwm_src1_all",  8'hFF, 8'hFF, 8'h55, 8'h55, 8'hFF};
      vecs[5] = '{"pwm_mixed_sel", 8'hFF, 8'hFF, 8'hE4, 8'h1B, 8'h66};
      vecs[6] = '{"pwm_low_en",    8'h0F, 8'hFF, 8'hE4, 8'h1B, 8'h06};
      vecs[7] = '{"mixed_modes",   8'hFF, 8'h0F, 8'hE4, 8'h1B, 8'hF6};
      vecs[8] = '{"sparse_en",     8'hAA, 8'hFF, 8'h55, 8'hFF, 8'h0A};

      // ---- reset state and first period on zero shadows ----
      rst               = 1'b1;
      bus.en_out        = 8'hFF;
      bus.en_pwm_out    = 8'hFF;
      bus.out_3_0_sel   = 8'h55;
      bus.out_7_4_sel   = 8'h55;
      bus.gen0_ch0_duty = 8'd0;
      bus.gen0_ch1_duty = 8'd255;
      bus.gen1_ch0_duty = 8'd255;
      bus.gen1_ch1_duty = 8'd0;
      bus.freq_div      = 8'h00;
      step(); step(); step();
      check("reset_out", bus.out, 8'h00);
      check("reset_wrap", bus.gen_wrap, 2'b00);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("first_period_low", bus.out, 8'h00);
      wait_wrap(0, 300, n);
      check("first_wrap_delay", n, 246);   // 10 + 246 = 256 edges after release
      check("first_wrap_both", bus.gen_wrap, 2'b11);

      // ---- routing / enable table, one-cycle latency ----
      foreach (vecs[k]) begin
         bus.en_out      = vecs[k].en;
         bus.en_pwm_out  = vecs[k].pwm;
         bus.out_3_0_sel = vecs[k].s30;
         bus.out_7_4_sel = vecs[k].s74;
         step();
         check(vecs[k].name, bus.out, vecs[k].exp);
      end

      // ---- duty 0 / 255 on gen1 to out[6]/out[7] across 3 periods ----
      bus.gen1_ch0_duty = 8'd0;
      bus.gen1_ch1_duty = 8'd255;
      bus.en_out        = 8'hC0;
      bus.en_pwm_out    = 8'hC0;
      bus.out_7_4_sel   = 8'hE0;
      wait_wrap(1, 300, n);
      check("gen1_wrap_seen", n > 0, 1'b1);
      step(); step();
      bad = 0;
      for (int i = 0; i < 768; i++) begin
         step();
         if (bus.out !== 8'h80) bad++;
      end
      check("duty0_255_steady", bad, 0);

      // ---- 50 % duty on out[0], repeating every 256 cycles ----
      bus.gen0_ch0_duty = 8'd128;
      bus.en_out        = 8'h01;
      bus.en_pwm_out    = 8'h01;
      bus.out_3_0_sel   = 8'h00;
      wait_wrap(0, 300, n);
      check("gen0_wrap_seen", n > 0, 1'b1);
      sample_g0(-1, 8'd0, ones, first_low);
      check("duty128_high", ones, 128);
      check("duty128_edge", first_low, 128);
      check("period256_wrap", bus.gen_wrap[0], 1'b1);
      bus.gen0_ch0_duty = 8'd64;            // takes effect at the next wrap
      sample_g0(-1, 8'd0, ones, first_low);
      check("duty128_repeat", ones, 128);

      // ---- duty change mid-period is deferred to the next wrap ----
      sample_g0(100, 8'd192, ones, first_low);
      check("duty64_kept", ones, 64);
      sample_g0(-1, 8'd0, ones, first_low);
      check("duty192_next", ones, 192);
      check("duty192_edge", first_low, 192);

      // ---- gen1 divider 3: 1024-cycle period, 256 high; gen0 unchanged ----
      bus.freq_div      = 8'h30;
      bus.gen1_ch1_duty = 8'd64;
      bus.en_out        = 8'h02;
      bus.en_pwm_out    = 8'h02;
      bus.out_3_0_sel   = 8'h0C;
      wait_wrap(1, 300, n);
      check("div_load_wrap", n > 0, 1'b1);
      n        = -1;
      ones     = 0;
      g0_wraps = 0;
      for (int i = 1; i <= 1100; i++) begin
         step();
         if (bus.out[1]) ones++;
         if (bus.gen_wrap[0]) g0_wraps++;
         if (bus.gen_wrap[1]) begin
            n = i;
            break;
         end
      end
      check("gen1_period1024", n, 1024);
      check("gen1_high256", ones, 256);
      check("gen0_wraps_in_1024", g0_wraps, 4);

      // ---- asynchronous reset mid-period ----
      bus.en_out      = 8'hFF;
      bus.en_pwm_out  = 8'hFF;
      bus.out_3_0_sel = 8'h55;
      bus.out_7_4_sel = 8'h55;
      step(); step();
      check("all_high_pre_rst", bus.out, 8'hFF);
      #2 rst = 1'b1;                        // between clock edges
      #1;
      check("async_rst_out", bus.out, 8'h00);
      check("async_rst_wrap", bus.gen_wrap, 2'b00);
      step(); step();
      check("rst_held_out", bus.out, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      wait_wrap(0, 300, n);
      check("post_rst_wrap", n, 256);
      check("post_rst_wrap_both", bus.gen_wrap, 2'b11);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
